// File: rtl/sal_rd_rsp_buf_if.sv
// Signal bundle between the DDR2 scheduler/DFI read path and the read-response buffer.
// The slave modport is the buffer's view; the master modport is the view of the driving logic.
interface sal_rd_rsp_buf_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 4,
    parameter int DATA_DEPTH = 16
);
    localparam int SLOT_W = $clog2(DATA_DEPTH) + 1;

    logic                  req_valid;
    logic                  req_ready;
    logic [ID_WIDTH-1:0]   req_id;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [SLOT_W-1:0]     free_slots;
    logic                  dfi_rddata_valid;
    logic [DATA_WIDTH-1:0] dfi_rddata;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  err_overflow;
    logic                  err_spurious;

    modport slave (
        input  req_valid, req_id, req_len, dfi_rddata_valid, dfi_rddata, rready,
        output req_ready, free_slots, rvalid, rid, rdata, rresp, rlast,
               err_overflow, err_spurious
    );

    modport master (
        output req_valid, req_id, req_len, dfi_rddata_valid, dfi_rddata, rready,
        input  req_ready, free_slots, rvalid, rid, rdata, rresp, rlast,
               err_overflow, err_spurious
    );
endinterface

// File: rtl/sal_rd_rsp_buf.sv
// Read-response buffer: reserves data slots when a read is committed, stores
// unthrottled DFI read beats and replays them on the AXI R channel with RID/RLAST.
module sal_rd_rsp_buf #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 4,
    parameter int CMD_DEPTH  = 8,
    parameter int DATA_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    sal_rd_rsp_buf_if.slave    bus
);
    localparam int CMD_AW  = $clog2(CMD_DEPTH);
    localparam int CMD_PW  = CMD_AW + 1;
    localparam int DATA_AW = $clog2(DATA_DEPTH);
    localparam int DATA_PW = DATA_AW + 1;
    localparam int SLOT_W  = DATA_AW + 1;

    logic [ID_WIDTH-1:0]   r_cmd_id  [CMD_DEPTH];
    logic [LEN_WIDTH-1:0]  r_cmd_len [CMD_DEPTH];
    logic [CMD_PW-1:0]     r_cmd_wptr;
    logic [CMD_PW-1:0]     r_cmd_rptr;
    logic [DATA_WIDTH-1:0] r_data_mem [DATA_DEPTH];
    logic [DATA_PW-1:0]    r_data_wptr;
    logic [DATA_PW-1:0]    r_data_rptr;
    logic [SLOT_W-1:0]     r_reserved;
    logic [SLOT_W-1:0]     r_unreturned;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic                  r_err_overflow;
    logic                  r_err_spurious;

    logic                  w_cmd_empty;
    logic                  w_cmd_full;
    logic                  w_data_empty;
    logic                  w_data_full;
    logic [SLOT_W-1:0]     w_req_beats;
    logic [SLOT_W-1:0]     w_free_slots;
    logic                  w_req_ready;
    logic                  w_push;
    logic [LEN_WIDTH-1:0]  w_head_len;
    logic                  w_rvalid;
    logic                  w_rlast;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_spurious;
    logic                  w_overflow;
    logic                  w_wr;

    assign w_cmd_empty  = (r_cmd_wptr == r_cmd_rptr);
    assign w_cmd_full   = ((r_cmd_wptr - r_cmd_rptr) == CMD_PW'(CMD_DEPTH));
    assign w_data_empty = (r_data_wptr == r_data_rptr);
    assign w_data_full  = ((r_data_wptr - r_data_rptr) == DATA_PW'(DATA_DEPTH));

    assign w_req_beats  = SLOT_W'(bus.req_len) + SLOT_W'(1);
    assign w_free_slots = SLOT_W'(DATA_DEPTH) - r_reserved;
    assign w_req_ready  = !w_cmd_full && (w_free_slots >= w_req_beats);
    assign w_push       = bus.req_valid && w_req_ready;

    assign w_head_len   = r_cmd_len[r_cmd_rptr[CMD_AW-1:0]];
    assign w_rvalid     = !w_data_empty;
    assign w_rlast      = w_rvalid && (r_beat_cnt == w_head_len);
    assign w_pop        = w_rvalid && bus.rready;
    assign w_last_pop   = w_pop && w_rlast;

    // A same-cycle pop frees the slot, so a beat into a full FIFO is only lost without one.
    assign w_spurious   = bus.dfi_rddata_valid && w_cmd_empty && (r_unreturned == '0);
    assign w_overflow   = bus.dfi_rddata_valid && !w_spurious && w_data_full && !w_pop;
    assign w_wr         = bus.dfi_rddata_valid && !w_spurious && !w_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_cmd_id[r_cmd_wptr[CMD_AW-1:0]]  <= bus.req_id;
            r_cmd_len[r_cmd_wptr[CMD_AW-1:0]] <= bus.req_len;
        end
        if (w_wr) begin
            r_data_mem[r_data_wptr[DATA_AW-1:0]] <= bus.dfi_rddata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_wptr     <= '0;
            r_cmd_rptr     <= '0;
            r_data_wptr    <= '0;
            r_data_rptr    <= '0;
            r_reserved     <= '0;
            r_unreturned   <= '0;
            r_beat_cnt     <= '0;
            r_err_overflow <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            if (w_push) begin
                r_cmd_wptr <= r_cmd_wptr + CMD_PW'(1);
            end
            if (w_last_pop) begin
                r_cmd_rptr <= r_cmd_rptr + CMD_PW'(1);
            end
            if (w_wr) begin
                r_data_wptr <= r_data_wptr + DATA_PW'(1);
            end
            if (w_pop) begin
                r_data_rptr <= r_data_rptr + DATA_PW'(1);
                r_beat_cnt  <= w_rlast ? '0 : r_beat_cnt + LEN_WIDTH'(1);
            end
            r_reserved <= r_reserved + (w_push ? w_req_beats : '0)
                                     - (w_pop ? SLOT_W'(1) : '0);
            r_unreturned <= r_unreturned + (w_push ? w_req_beats : '0)
                                         - ((w_wr && (r_unreturned != '0)) ? SLOT_W'(1) : '0);
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.free_slots   = w_free_slots;
    assign bus.rvalid       = w_rvalid;
    assign bus.rid          = w_rvalid ? r_cmd_id[r_cmd_rptr[CMD_AW-1:0]] : '0;
    assign bus.rdata        = w_rvalid ? r_data_mem[r_data_rptr[DATA_AW-1:0]] : '0;
    assign bus.rresp        = 2'b00;
    assign bus.rlast        = w_rlast;
    assign bus.err_overflow = r_err_overflow;
    assign bus.err_spurious = r_err_spurious;
endmodule

// File: tb/tb_sal_rd_rsp_buf.sv
// Directed self-checking bench for sal_rd_rsp_buf: one task per scenario with
// hand-computed expected R-channel beats, reservation counts and error flags.
module tb_sal_rd_rsp_buf;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sal_rd_rsp_buf_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .LEN_WIDTH(4), .DATA_DEPTH(16)) bus ();

    sal_rd_rsp_buf #(
        .ID_WIDTH(4), .DATA_WIDTH(64), .LEN_WIDTH(4), .CMD_DEPTH(8), .DATA_DEPTH(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int k);
        return 64'hDA7A_0000_0000_0000 | 64'(k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid        = 1'b0;
        bus.req_id           = '0;
        bus.req_len          = '0;
        bus.dfi_rddata_valid = 1'b0;
        bus.dfi_rddata       = '0;
    endtask

    // Packs {rvalid, rid, rlast, rdata} so one comparison covers a whole R beat.
    task automatic test_reset();
        logic [69:0] got, want;
        idle();
        bus.rready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        got  = {bus.rvalid, bus.rid, bus.rlast, bus.rdata};
        want = {1'b0, 4'd0, 1'b0, 64'd0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL reset_rchan got %h want %h", got, want);
        end
        checks++;
        if ({bus.free_slots, bus.req_ready, bus.err_overflow, bus.err_spurious, bus.rresp} !== {5'd16, 1'b1, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("[TB] FAIL reset_status got free=%0d rdy=%b ovf=%b spu=%b rresp=%b want free=16 rdy=1 ovf=0 spu=0 rresp=00",
                     bus.free_slots, bus.req_ready, bus.err_overflow, bus.err_spurious, bus.rresp);
        end
        step();
    endtask

    task automatic test_single();
        logic [69:0] got, want;
        int exp_free;
        idle();
        bus.rready    = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd3;
        bus.req_len   = 4'd3;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ready got %b want 1", bus.req_ready);
        end
        step();
        idle();
        for (int c = 0; c <= 5; c++) begin
            bus.dfi_rddata_valid = (c < 4);
            bus.dfi_rddata       = pat(c);
            #1;
            exp_free = 12 + ((c >= 1) ? c - 1 : 0);
            got  = {bus.rvalid, bus.rid, bus.rlast, bus.rdata};
            if (c == 0 || c == 5) want = {1'b0, 4'd0, 1'b0, 64'd0};
            else                  want = {1'b1, 4'd3, (c == 4), pat(c - 1)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL single_beat c=%0d got %h want %h", c, got, want);
            end
            checks++;
            if (bus.free_slots !== 5'(exp_free)) begin
                errors++;
                $display("[TB] FAIL single_free c=%0d got %0d want %0d", c, bus.free_slots, exp_free);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [69:0] got, want;
        int  eid   [3] = '{1, 1, 2};
        bit  elast [3] = '{0, 1, 1};
        idle();
        bus.rready    = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd1;
        bus.req_len   = 4'd1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready1 got %b want 1", bus.req_ready);
        end
        step();
        bus.req_id  = 4'd2;
        bus.req_len = 4'd0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.free_slots !== 5'd14) begin
            errors++;
            $display("[TB] FAIL b2b_ready2 got rdy=%b free=%0d want rdy=1 free=14", bus.req_ready, bus.free_slots);
        end
        step();
        idle();
        for (int c = 0; c <= 4; c++) begin
            bus.dfi_rddata_valid = (c < 3);
            bus.dfi_rddata       = pat(16 + c);
            #1;
            got = {bus.rvalid, bus.rid, bus.rlast, bus.rdata};
            if (c == 0 || c == 4) want = {1'b0, 4'd0, 1'b0, 64'd0};
            else                  want = {1'b1, 4'(eid[c-1]), elast[c-1], pat(16 + c - 1)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL b2b_beat c=%0d got %h want %h", c, got, want);
            end
            step();
        end
        checks++;
        if (bus.free_slots !== 5'd16) begin
            errors++;
            $display("[TB] FAIL b2b_free got %0d want 16", bus.free_slots);
        end
    endtask

    task automatic test_stall();
        logic [69:0] got, want;
        idle();
        bus.rready    = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd5;
        bus.req_len   = 4'd15;
        step();
        idle();
        for (int c = 0; c <= 26; c++) begin
            bus.dfi_rddata_valid = (c < 16);
            bus.dfi_rddata       = pat(32 + c);
            bus.rready           = (c >= 10);
            #1;
            got = {bus.rvalid, bus.rid, bus.rlast, bus.rdata};
            if (c == 0 || c == 26) want = {1'b0, 4'd0, 1'b0, 64'd0};
            else if (c < 10)       want = {1'b1, 4'd5, 1'b0, pat(32)};
            else                   want = {1'b1, 4'd5, (c == 25), pat(32 + c - 10)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL stall_beat c=%0d got %h want %h", c, got, want);
            end
            step();
        end
        checks++;
        if (bus.err_overflow !== 1'b0 || bus.free_slots !== 5'd16) begin
            errors++;
            $display("[TB] FAIL stall_end got ovf=%b free=%0d want ovf=0 free=16", bus.err_overflow, bus.free_slots);
        end
    endtask

    task automatic test_reservation();
        int exp_free;
        idle();
        bus.rready    = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd6;
        bus.req_len   = 4'd11;
        step();
        idle();
        bus.req_len = 4'd7;
        for (int c = 0; c <= 13; c++) begin
            bus.dfi_rddata_valid = (c < 12);
            bus.dfi_rddata       = pat(64 + c);
            #1;
            exp_free = 4 + ((c >= 1) ? c - 1 : 0);
            checks++;
            if (bus.free_slots !== 5'(exp_free) || bus.req_ready !== (exp_free >= 8)) begin
                errors++;
                $display("[TB] FAIL resv c=%0d got free=%0d rdy=%b want free=%0d rdy=%b",
                         c, bus.free_slots, bus.req_ready, exp_free, (exp_free >= 8));
            end
            step();
        end
        bus.req_len = 4'd0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL resv_drain got rvalid=%b want 0", bus.rvalid);
        end
    endtask

    task automatic test_errors();
        idle();
        bus.rready           = 1'b1;
        bus.dfi_rddata_valid = 1'b1;
        bus.dfi_rddata       = pat(99);
        step();
        idle();
        #1;
        checks++;
        if ({bus.err_spurious, bus.err_overflow, bus.rvalid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL spurious_set got spu=%b ovf=%b rvalid=%b want 1 0 0",
                     bus.err_spurious, bus.err_overflow, bus.rvalid);
        end
        step();
        step();
        checks++;
        if ({bus.err_spurious, bus.rvalid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL spurious_sticky got spu=%b rvalid=%b want 1 0", bus.err_spurious, bus.rvalid);
        end
        bus.rready    = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd9;
        bus.req_len   = 4'd15;
        step();
        idle();
        for (int c = 0; c <= 16; c++) begin
            bus.dfi_rddata_valid = 1'b1;
            bus.dfi_rddata       = pat(96 + c);
            step();
        end
        idle();
        #1;
        checks++;
        if ({bus.err_overflow, bus.rvalid, bus.rdata} !== {1'b1, 1'b1, pat(96)}) begin
            errors++;
            $display("[TB] FAIL overflow_set got ovf=%b rvalid=%b rdata=%h want 1 1 %h",
                     bus.err_overflow, bus.rvalid, bus.rdata, pat(96));
        end
        bus.rready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++;
            if ({bus.rvalid, bus.rid, bus.rlast, bus.rdata} !== {1'b1, 4'd9, (c == 15), pat(96 + c)}) begin
                errors++;
                $display("[TB] FAIL overflow_drain c=%0d got %h want %h", c,
                         {bus.rvalid, bus.rid, bus.rlast, bus.rdata}, {1'b1, 4'd9, (c == 15), pat(96 + c)});
            end
            step();
        end
        checks++;
        if ({bus.rvalid, bus.err_overflow, bus.err_spurious} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL errors_sticky got rvalid=%b ovf=%b spu=%b want 0 1 1",
                     bus.rvalid, bus.err_overflow, bus.err_spurious);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        bus.rready    = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd4;
        bus.req_len   = 4'd3;
        step();
        idle();
        for (int c = 0; c < 2; c++) begin
            bus.dfi_rddata_valid = 1'b1;
            bus.dfi_rddata       = pat(112 + c);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.rvalid, bus.rid, bus.rlast, bus.free_slots, bus.err_overflow, bus.err_spurious} !==
            {1'b0, 4'd0, 1'b0, 5'd16, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid got rvalid=%b rid=%0d rlast=%b free=%0d ovf=%b spu=%b want 0 0 0 16 0 0",
                     bus.rvalid, bus.rid, bus.rlast, bus.free_slots, bus.err_overflow, bus.err_spurious);
        end
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd7;
        bus.req_len   = 4'd0;
        step();
        idle();
        bus.dfi_rddata_valid = 1'b1;
        bus.dfi_rddata       = pat(128);
        step();
        idle();
        bus.rready = 1'b1;
        #1;
        checks++;
        if ({bus.rvalid, bus.rid, bus.rlast, bus.rdata} !== {1'b1, 4'd7, 1'b1, pat(128)}) begin
            errors++;
            $display("[TB] FAIL reset_new_beat got %h want %h",
                     {bus.rvalid, bus.rid, bus.rlast, bus.rdata}, {1'b1, 4'd7, 1'b1, pat(128)});
        end
        step();
        checks++;
        if ({bus.rvalid, bus.free_slots, bus.err_spurious} !== {1'b0, 5'd16, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_new_end got rvalid=%b free=%0d spu=%b want 0 16 0",
                     bus.rvalid, bus.free_slots, bus.err_spurious);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.rready = 1'b0;
        idle();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reservation();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
